// File: rtl/cnt_cmd_sequencer_if.sv
// Command handshake between cnt_cmd_sequencer and fsm_counter.
// master = sequencer side, slave = counter side.
interface cnt_cmd_sequencer_if #(
   parameter int CNT_BIT = 31
) ();
   logic               o_run;
   logic [CNT_BIT-1:0] o_num_cnt;
   logic               i_idle;
   logic               i_running;
   logic               i_done;

   modport master (
      output o_run,
      output o_num_cnt,
      input  i_idle,
      input  i_running,
      input  i_done
   );

   modport slave (
      input  o_run,
      input  o_num_cnt,
      output i_idle,
      output i_running,
      output i_done
   );
endinterface

// File: rtl/cnt_cmd_sequencer.sv
// Queues software count commands and issues them to fsm_counter,
// tracking completions, last-run cycle count and sticky errors.
module cnt_cmd_sequencer #(
   parameter int CNT_BIT = 31,
   parameter int DEPTH   = 4,
   parameter int PTR_BIT = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_push,
   input  logic [CNT_BIT-1:0] i_num_cnt,
   input  logic               i_flush,
   input  logic               i_clr,
   output logic [PTR_BIT:0]   o_level,
   output logic               o_full,
   output logic               o_empty,
   output logic               o_busy,
   output logic [1:0]         o_err,
   output logic [15:0]        o_done_cnt,
   output logic [31:0]        o_last_cycles,
   cnt_cmd_sequencer_if.master cnt_if
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [PTR_BIT-1:0] PTR_ONE  = 1;
   localparam logic [PTR_BIT:0]   LVL_ONE  = 1;
   localparam logic [PTR_BIT:0]   LVL_FULL = (PTR_BIT+1)'(DEPTH);

   logic [CNT_BIT-1:0] mem_q [DEPTH];
   logic [PTR_BIT-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_BIT-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_BIT:0]   level_q, level_d;

   logic [1:0]         state_q, state_d;
   logic [31:0]        cyc_q, cyc_d;
   logic               run_q, run_d;
   logic [CNT_BIT-1:0] num_q, num_d;
   logic [31:0]        last_q, last_d;
   logic [15:0]        done_q, done_d;
   logic [1:0]         err_q, err_d;

   logic full, empty, issue;
   logic push_ok, err_ovf, err_zero;
   logic [31:0] cyc_inc;

   assign full  = (level_q == LVL_FULL);
   assign empty = (level_q == '0);
   assign issue = (state_q == S_IDLE) && !empty
                  && cnt_if.i_idle && !i_flush;

   // Flush outranks everything, then zero count, then full.
   assign err_zero = i_push && !i_flush
                     && (i_num_cnt == '0);
   assign err_ovf  = i_push && !i_flush
                     && (i_num_cnt != '0) && full;
   assign push_ok  = i_push && !i_flush
                     && (i_num_cnt != '0) && !full;

   assign cyc_inc = (cyc_q == 32'hFFFF_FFFF) ?
                    cyc_q : cyc_q + 32'd1;

   // FIFO pointer and occupancy next state.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (i_flush) begin
         rd_ptr_d = wr_ptr_q;
         level_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (issue)   rd_ptr_d = rd_ptr_q + PTR_ONE;
         unique case ({push_ok, issue})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
         endcase
      end
   end

   // Issue/track FSM, cycle counter and status next state.
   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      run_d   = 1'b0;
      num_d   = num_q;
      last_d  = last_q;
      done_d  = done_q;
      unique case (state_q)
         S_IDLE: begin
            if (issue) begin
               num_d   = mem_q[rd_ptr_q];
               run_d   = 1'b1;
               cyc_d   = 32'd1;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_if.i_done) begin
               state_d = S_DONE;
            end else begin
               cyc_d = cyc_inc;
               if (cnt_if.i_running) state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (cnt_if.i_done) state_d = S_DONE;
            else               cyc_d   = cyc_inc;
         end
         S_DONE: begin
            last_d  = cyc_q;
            if (done_q != 16'hFFFF) done_d = done_q + 16'd1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (i_clr) done_d = '0;
      err_d = (i_clr ? 2'b00 : err_q) | {err_zero, err_ovf};
   end

   // Command storage; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= i_num_cnt;
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         state_q  <= S_IDLE;
         cyc_q    <= '0;
         run_q    <= 1'b0;
         num_q    <= '0;
         last_q   <= '0;
         done_q   <= '0;
         err_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         state_q  <= state_d;
         cyc_q    <= cyc_d;
         run_q    <= run_d;
         num_q    <= num_d;
         last_q   <= last_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign o_level       = level_q;
   assign o_full        = full;
   assign o_empty       = empty;
   assign o_busy        = (state_q != S_IDLE);
   assign o_err         = err_q;
   assign o_done_cnt    = done_q;
   assign o_last_cycles = last_q;
   assign cnt_if.o_run     = run_q;
   assign cnt_if.o_num_cnt = num_q;

endmodule
